// File: rtl/pci_bus_arbiter.sv
// Round-robin arbiter for the shared PCI bus: active-low one-hot grants, bus
// parking on the last owner, and revocation of grants the owner leaves unused.
module pci_bus_arbiter #(
  parameter int N           = 4,
  parameter int IDX_W       = 2,
  parameter int PARK_ID     = 0,
  parameter int GNT_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     NREQ,
  input  logic             NFRAME,
  input  logic             NIRED,
  output logic [N-1:0]     NGNT,
  output logic [IDX_W-1:0] owner,
  output logic             gnt_valid,
  output logic             timeout,
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {
    HANDOFF = 2'd0,
    PARK    = 2'd1,
    GRANT   = 2'd2,
    ACTIVE  = 2'd3
  } state_t;

  state_t           state;
  logic [7:0]       idle_cnt;
  logic [N-1:0]     req;
  logic [N-1:0]     owner_hole;
  logic             own_req;
  logic             other_req;
  logic             any_req;
  logic             bus_idle;
  logic             found;
  logic [IDX_W-1:0] winner;

  // All ones except a zero at idx: the NGNT pattern for a grant to idx.
  function automatic logic [N-1:0] ngnt_for(input logic [IDX_W-1:0] idx);
    logic [N-1:0] v;
    v      = '1;
    v[idx] = 1'b0;
    return v;
  endfunction

  assign req        = ~NREQ;
  assign bus_idle   = NFRAME & NIRED;
  assign owner_hole = ngnt_for(owner);
  assign any_req    = |req;
  assign own_req    = |(req & ~owner_hole);
  assign other_req  = |(req & owner_hole);
  assign fsm_state  = state;

  // Scan owner+1 .. owner+N so the current owner is the last candidate.
  always_comb begin
    winner = owner;
    found  = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!found && req[(int'(owner) + k) % N]) begin
        winner = IDX_W'((int'(owner) + k) % N);
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= HANDOFF;
      owner     <= IDX_W'(PARK_ID);
      NGNT      <= '1;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
      idle_cnt  <= 8'd0;
    end else begin
      timeout <= 1'b0;
      case (state)
        HANDOFF: begin
          if (bus_idle) begin
            gnt_valid <= 1'b1;
            if (any_req) begin
              state    <= GRANT;
              owner    <= winner;
              NGNT     <= ngnt_for(winner);
              idle_cnt <= 8'd0;
            end else begin
              state <= PARK;
              NGNT  <= owner_hole;
            end
          end
        end
        PARK: begin
          if (!NFRAME) begin
            state <= ACTIVE;
          end else if (other_req) begin
            state     <= HANDOFF;
            NGNT      <= '1;
            gnt_valid <= 1'b0;
          end else if (own_req) begin
            state    <= GRANT;
            idle_cnt <= 8'd0;
          end
        end
        GRANT: begin
          // A starting transaction beats both the timeout and competing requests.
          if (!NFRAME) begin
            state <= ACTIVE;
          end else if (bus_idle && idle_cnt == 8'(GNT_TIMEOUT - 1)) begin
            state     <= HANDOFF;
            NGNT      <= '1;
            gnt_valid <= 1'b0;
            timeout   <= 1'b1;
          end else if (other_req && !own_req) begin
            state     <= HANDOFF;
            NGNT      <= '1;
            gnt_valid <= 1'b0;
          end else if (!any_req) begin
            state <= PARK;
          end else if (bus_idle) begin
            idle_cnt <= idle_cnt + 8'd1;
          end
        end
        ACTIVE: begin
          // The preempted owner finishes under its own latency timer.
          if (other_req) begin
            state     <= HANDOFF;
            NGNT      <= '1;
            gnt_valid <= 1'b0;
          end else if (bus_idle) begin
            if (own_req) begin
              state    <= GRANT;
              idle_cnt <= 8'd0;
            end else begin
              state <= PARK;
            end
          end
        end
        default: begin
          state     <= HANDOFF;
          NGNT      <= '1;
          gnt_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Directed bench for pci_bus_arbiter (N=4, PARK_ID=0, GNT_TIMEOUT=16).
module tb_pci_bus_arbiter;

  localparam logic [1:0] S_HANDOFF = 2'd0;
  localparam logic [1:0] S_PARK    = 2'd1;
  localparam logic [1:0] S_GRANT   = 2'd2;
  localparam logic [1:0] S_ACTIVE  = 2'd3;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] NREQ;
  logic       NFRAME;
  logic       NIRED;
  logic [3:0] NGNT;
  logic [1:0] owner;
  logic       gnt_valid;
  logic       timeout;
  logic [1:0] fsm_state;

  int n_cmp = 0;
  int n_err = 0;

  logic [1:0] rr_owner [5];
  logic [3:0] rr_ngnt  [5];

  pci_bus_arbiter #(.N(4), .IDX_W(2), .PARK_ID(0), .GNT_TIMEOUT(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .NREQ      (NREQ),
    .NFRAME    (NFRAME),
    .NIRED     (NIRED),
    .NGNT      (NGNT),
    .owner     (owner),
    .gnt_valid (gnt_valid),
    .timeout   (timeout),
    .fsm_state (fsm_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_grant(input string tag, input logic [3:0] ngnt_exp,
                             input logic [1:0] owner_exp, input logic [1:0] state_exp);
    check({tag, "_ngnt"}, 8'(NGNT), 8'(ngnt_exp));
    check({tag, "_owner"}, 8'(owner), 8'(owner_exp));
    check({tag, "_state"}, 8'(fsm_state), 8'(state_exp));
    check({tag, "_valid"}, 8'(gnt_valid), 8'(ngnt_exp != 4'b1111));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rr_owner = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
    rr_ngnt  = '{4'b1011, 4'b0111, 4'b1110, 4'b1101, 4'b1011};

    // Reset and park
    reset = 1'b1; NREQ = 4'b1111; NFRAME = 1'b1; NIRED = 1'b1;
    #2;
    check_grant("reset", 4'b1111, 2'd0, S_HANDOFF);
    check("reset_timeout", 8'(timeout), 8'd0);
    #40 reset = 1'b0;
    tick();
    check_grant("park0", 4'b1110, 2'd0, S_PARK);

    // Parked owner requests: no dead cycle
    NREQ = 4'b1110;
    tick();
    check_grant("park_self", 4'b1110, 2'd0, S_GRANT);
    NREQ = 4'b1111;
    tick();
    check_grant("back_park", 4'b1110, 2'd0, S_PARK);

    // Non-owner request
    NREQ = 4'b1011;
    tick();
    check_grant("req2_hand", 4'b1111, 2'd0, S_HANDOFF);
    tick();
    check_grant("req2_gnt", 4'b1011, 2'd2, S_GRANT);
    NFRAME = 1'b0; NIRED = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_grant("burst2", 4'b1011, 2'd2, S_ACTIVE);
    end
    NFRAME = 1'b1; NIRED = 1'b1;
    tick();
    check_grant("burst2_end", 4'b1011, 2'd2, S_GRANT);

    // Move to owner 1, then round-robin with everybody requesting
    NREQ = 4'b1101;
    tick();
    check_grant("to1_hand", 4'b1111, 2'd2, S_HANDOFF);
    tick();
    check_grant("to1_gnt", 4'b1101, 2'd1, S_GRANT);
    NREQ = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      NFRAME = 1'b0; NIRED = 1'b0;
      tick();
      check("rr_active_state", 8'(fsm_state), 8'(S_ACTIVE));
      NFRAME = 1'b1;
      tick();
      check("rr_hand_ngnt", 8'(NGNT), 8'h0f);
      NIRED = 1'b1;
      tick();
      check_grant("rr_gnt", rr_ngnt[i], rr_owner[i], S_GRANT);
    end

    // Preemption of active master 0 by master 3
    NREQ = 4'b1110;
    tick();
    check_grant("to0_hand", 4'b1111, 2'd2, S_HANDOFF);
    tick();
    check_grant("to0_gnt", 4'b1110, 2'd0, S_GRANT);
    NFRAME = 1'b0; NIRED = 1'b0;
    tick();
    check_grant("act0", 4'b1110, 2'd0, S_ACTIVE);
    NREQ = 4'b0110;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_grant("preempt_hold", 4'b1111, 2'd0, S_HANDOFF);
    end
    NFRAME = 1'b1; NIRED = 1'b1;
    tick();
    check_grant("preempt_gnt3", 4'b0111, 2'd3, S_GRANT);

    // Timeout on an unused grant to master 1 while master 2 waits
    NREQ = 4'b1001;
    tick();
    check_grant("to1b_hand", 4'b1111, 2'd3, S_HANDOFF);
    tick();
    check_grant("to1b_gnt", 4'b1101, 2'd1, S_GRANT);
    for (int i = 0; i < 15; i++) begin
      tick();
      check("to_wait_ngnt", 8'(NGNT), 8'h0d);
      check("to_wait_pulse", 8'(timeout), 8'd0);
    end
    tick();
    check("to_pulse", 8'(timeout), 8'd1);
    check_grant("to_hand", 4'b1111, 2'd1, S_HANDOFF);
    tick();
    check("to_pulse_end", 8'(timeout), 8'd0);
    check_grant("to_gnt2", 4'b1011, 2'd2, S_GRANT);

    // Reset while master 2 holds the bus
    NFRAME = 1'b0; NIRED = 1'b0;
    tick();
    check_grant("rst_act2", 4'b1011, 2'd2, S_ACTIVE);
    #2 reset = 1'b1;
    #1;
    check_grant("rst_mid", 4'b1111, 2'd0, S_HANDOFF);
    NREQ = 4'b1111; NFRAME = 1'b1; NIRED = 1'b1;
    #3 reset = 1'b0;
    tick();
    check_grant("rst_park", 4'b1110, 2'd0, S_PARK);

    // Parked bus taken directly by the owner's FRAME#
    NFRAME = 1'b0;
    tick();
    check_grant("park_act", 4'b1110, 2'd0, S_ACTIVE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
